// File: rtl/image_issue_scheduler_pkg.sv
// Shared types for the image issue scheduler: datapath instruction/result formats,
// the supported-opcode list and the issue-queue entry layout.
package image_issue_scheduler_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned PIX_N = 4;

    typedef logic [PIX_N-1:0][PIX_W-1:0] pixelMatrix_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_INV  = 3'd4,
        OP_BLUR = 3'd5
    } opcode_t;

    typedef struct packed {
        opcode_t      opcode;
        pixelMatrix_t cell_a;
        pixelMatrix_t cell_b;
    } instruction_t;

    typedef struct packed {
        logic         id;
        instruction_t iw;
    } sched_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    localparam int unsigned N_SUPPORTED = 1;
    localparam opcode_t SUPPORTED_OPS [N_SUPPORTED] = '{OP_ADD};

    // True when the datapath produces a meaningful result for this opcode.
    function automatic logic is_supported(input opcode_t op);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_SUPPORTED; i++) begin
            if (SUPPORTED_OPS[i] == op) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/image_issue_fifo.sv
// Issue queue: power-of-two FIFO with registered occupancy; push ignored when full,
// pop ignored when empty. Head entry is visible combinationally on dout.
module image_issue_fifo
    import image_issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = sched_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/image_issue_scheduler.sv
// Round-robin host/DMA arbiter feeding a shared issue queue in front of the combinational
// ImageProcessor datapath; owns dp_iw and registers each result with its requester tag.
module image_issue_scheduler
    import image_issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  instruction_t           req_iw [2],
    output instruction_t           dp_iw,
    input  pixelMatrix_t           dp_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output pixelMatrix_t           res_data,
    output logic                   res_id,
    output logic                   res_err,
    output logic [$clog2(DEPTH):0] q_count,
    output logic [CNT_W-1:0]       issued_count,
    output sched_state_t           state_c
);

    logic         rr_ptr;
    logic         grant_c;
    logic         push_c;
    logic         issue_c;
    logic         unsupported_c;
    logic         full;
    logic         empty;
    sched_entry_t entry_in;
    sched_entry_t head;

    image_issue_fifo #(
        .DEPTH (DEPTH),
        .T     (sched_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (issue_c),
        .din   (entry_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (q_count)
    );

    // Arbitration and issue decode; ready is withheld during reset and whenever the queue is full.
    always_comb begin
        req_ready      = '0;
        grant_c        = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        if (!reset && !full) req_ready[grant_c] = 1'b1;
        push_c         = req_valid[grant_c] && req_ready[grant_c];
        entry_in.id    = grant_c;
        entry_in.iw    = req_iw[grant_c];
        issue_c        = !empty && (!res_valid || res_ready);
        dp_iw          = issue_c ? head.iw : '0;
        unsupported_c  = !is_supported(head.iw.opcode);
    end

    // Coverage-only view of the scheduler phase.
    always_comb begin
        state_c = ST_IDLE;
        if (issue_c) begin
            state_c = ST_RUN;
        end else if (res_valid && !res_ready) begin
            state_c = ST_STALL;
        end else if (res_valid) begin
            state_c = ST_DRAIN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_id       <= 1'b0;
            res_err      <= 1'b0;
            issued_count <= '0;
        end else begin
            if (push_c) rr_ptr <= ~grant_c;
            if (issue_c) begin
                res_valid    <= 1'b1;
                res_data     <= unsupported_c ? '0 : dp_result;
                res_id       <= head.id;
                res_err      <= unsupported_c;
                issued_count <= issued_count + CNT_W'(1);
            end else if (res_ready) begin
                res_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_image_issue_scheduler.sv
// Directed + randomized bench for image_issue_scheduler against a queue-based reference model.
module tb_image_issue_scheduler;
    import image_issue_scheduler_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    instruction_t           req_iw [2];
    instruction_t           dp_iw;
    pixelMatrix_t           dp_result;
    logic                   res_valid;
    logic                   res_ready;
    pixelMatrix_t           res_data;
    logic                   res_id;
    logic                   res_err;
    logic [$clog2(DEPTH):0] q_count;
    logic [CNT_W-1:0]       issued_count;
    sched_state_t           state_c;

    int n_assert = 0;
    int n_fail   = 0;

    sched_entry_t     mq [$];
    logic             m_rr;
    logic             m_rv;
    logic             m_id;
    logic             m_err;
    pixelMatrix_t     m_data;
    logic [CNT_W-1:0] m_cnt;
    int               push_log [$];
    int               res_log [$];

    always #5 clk = ~clk;

    image_issue_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_iw       (req_iw),
        .dp_iw        (dp_iw),
        .dp_result    (dp_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_id       (res_id),
        .res_err      (res_err),
        .q_count      (q_count),
        .issued_count (issued_count),
        .state_c      (state_c)
    );

    // Stand-in for the combinational ImageProcessor datapath.
    function automatic pixelMatrix_t ip_model(input instruction_t iw);
        pixelMatrix_t r;
        for (int p = 0; p < int'(PIX_N); p++) begin
            case (iw.opcode)
                OP_ADD:  r[p] = iw.cell_a[p] + iw.cell_b[p];
                OP_SUB:  r[p] = iw.cell_a[p] - iw.cell_b[p];
                default: r[p] = iw.cell_a[p] ^ iw.cell_b[p];
            endcase
        end
        return r;
    endfunction

    assign dp_result = ip_model(dp_iw);

    function automatic pixelMatrix_t exp_res(input instruction_t iw);
        pixelMatrix_t r;
        r = '0;
        if (iw.opcode == OP_ADD) begin
            for (int p = 0; p < int'(PIX_N); p++) r[p] = iw.cell_a[p] + iw.cell_b[p];
        end
        return r;
    endfunction

    function automatic instruction_t rand_iw();
        instruction_t r;
        int unsigned  sel;
        sel      = $urandom_range(0, 7);
        r.opcode = (sel < 5) ? OP_ADD : opcode_t'(3'(sel - 4));
        r.cell_a = $urandom;
        r.cell_b = $urandom;
        return r;
    endfunction

    function automatic instruction_t mk_iw(input opcode_t op, input logic [7:0] a, input logic [7:0] b);
        instruction_t r;
        r.opcode = op;
        r.cell_a = {PIX_N{a}};
        r.cell_b = {PIX_N{b}};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr   = 1'b0;
        m_rv   = 1'b0;
        m_id   = 1'b0;
        m_err  = 1'b0;
        m_data = '0;
        m_cnt  = '0;
    endtask

    // One clock: check DUT against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic         g;
        logic         m_push;
        logic         m_issue;
        logic         m_full;
        logic [1:0]   exp_ready;
        instruction_t exp_dp;
        sched_entry_t e;
        @(negedge clk);
        m_full    = (mq.size() >= int'(DEPTH));
        g         = req_valid[m_rr] ? m_rr : !m_rr;
        m_push    = req_valid[g] && !m_full;
        exp_ready = m_full ? 2'b00 : (g ? 2'b10 : 2'b01);
        m_issue   = (mq.size() != 0) && (!m_rv || res_ready);
        exp_dp    = '0;
        if (m_issue) exp_dp = mq[0].iw;
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        chk("dp_iw", 128'(dp_iw), 128'(exp_dp));
        chk("q_count", 128'(q_count), 128'(mq.size()));
        chk("res_valid", 128'(res_valid), 128'(m_rv));
        chk("res_data", 128'(res_data), 128'(m_data));
        chk("res_id", 128'(res_id), 128'(m_id));
        chk("res_err", 128'(res_err), 128'(m_err));
        chk("issued_count", 128'(issued_count), 128'(m_cnt));
        if (req_valid[0] && req_ready[0]) push_log.push_back(0);
        if (req_valid[1] && req_ready[1]) push_log.push_back(1);
        if (res_valid && res_ready) res_log.push_back(int'(res_id));
        @(posedge clk);
        if (m_issue) begin
            e      = mq.pop_front();
            m_rv   = 1'b1;
            m_data = exp_res(e.iw);
            m_id   = e.id;
            m_err  = (e.iw.opcode != OP_ADD);
            m_cnt  = m_cnt + 1'b1;
        end else if (m_rv && res_ready) begin
            m_rv = 1'b0;
        end
        if (m_push) begin
            e.id = g;
            e.iw = req_iw[g];
            mq.push_back(e);
            m_rr = !g;
        end
        #1;
    endtask

    task automatic flush();
        req_valid = 2'b00;
        res_ready = 1'b1;
        repeat (DEPTH + 3) cycle();
    endtask

    initial begin
        logic [CNT_W-1:0] cnt_before;
        reset     = 1'b1;
        req_valid = 2'b00;
        res_ready = 1'b0;
        req_iw[0] = '0;
        req_iw[1] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) cycle();

        // Async reset with work queued and a result pending.
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            req_iw[0] = rand_iw();
            cycle();
        end
        chk("pre_reset_q_count", 128'(q_count), 128'(3));
        chk("pre_reset_res_valid", 128'(res_valid), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_dp_iw", 128'(dp_iw), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_data", 128'(res_data), 128'(0));
        chk("rst_res_id", 128'(res_id), 128'(0));
        chk("rst_res_err", 128'(res_err), 128'(0));
        chk("rst_q_count", 128'(q_count), 128'(0));
        chk("rst_issued_count", 128'(issued_count), 128'(0));
        model_reset();
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;
        cycle();
        chk("post_reset_q_count", 128'(q_count), 128'(0));

        // Both requesters streaming: grants and result ids alternate.
        push_log.delete();
        res_log.delete();
        req_valid = 2'b11;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_iw[0] = mk_iw(OP_ADD, 8'($urandom), 8'($urandom));
            req_iw[1] = mk_iw(OP_ADD, 8'($urandom), 8'($urandom));
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("grant_order_%0d", k), 128'(push_log[k]), 128'(k % 2));
            chk($sformatf("res_id_order_%0d", k), 128'(res_log[k]), 128'(k % 2));
        end
        flush();

        // Backpressure: queue fills, ready drops, then five results drain.
        req_valid = 2'b01;
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_iw[0] = rand_iw();
            cycle();
        end
        chk("stall_q_full", 128'(q_count), 128'(DEPTH));
        chk("stall_req_ready", 128'(req_ready), 128'(0));
        req_valid = 2'b00;
        res_ready = 1'b1;
        res_log.delete();
        repeat (8) cycle();
        chk("drain_count", 128'(res_log.size()), 128'(5));
        flush();

        // Directed ADD.
        cnt_before = m_cnt;
        req_iw[0]  = mk_iw(OP_ADD, 8'h10, 8'h05);
        req_valid  = 2'b01;
        cycle();
        req_valid  = 2'b00;
        cycle();
        chk("add_data", 128'(res_data), 128'({PIX_N{8'h15}}));
        chk("add_err", 128'(res_err), 128'(0));
        chk("add_count", 128'(issued_count), 128'(cnt_before + 1'b1));
        flush();

        // Unsupported opcode followed by ADD.
        req_valid = 2'b01;
        req_iw[0] = mk_iw(OP_SUB, 8'h40, 8'h01);
        cycle();
        req_iw[0] = mk_iw(OP_ADD, 8'h21, 8'h03);
        cycle();
        req_valid = 2'b00;
        chk("unsup_err", 128'(res_err), 128'(1));
        chk("unsup_data", 128'(res_data), 128'(0));
        cycle();
        chk("after_unsup_err", 128'(res_err), 128'(0));
        chk("after_unsup_data", 128'(res_data), 128'({PIX_N{8'h24}}));
        flush();

        // Counter wrap.
        force dut.issued_count = {CNT_W{1'b1}};
        #1 release dut.issued_count;
        m_cnt = {CNT_W{1'b1}};
        req_iw[0] = rand_iw();
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("count_wrap", 128'(issued_count), 128'(0));
        flush();

        // Simultaneous push and pop at occupancy 2.
        req_valid = 2'b01;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_iw[0] = rand_iw();
            cycle();
        end
        chk("pp_pre_q_count", 128'(q_count), 128'(2));
        res_ready = 1'b1;
        req_iw[0] = rand_iw();
        cycle();
        chk("pp_q_count", 128'(q_count), 128'(2));
        flush();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            req_valid = 2'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
            req_iw[0] = rand_iw();
            req_iw[1] = rand_iw();
            cycle();
        end
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
